msync_sequencer: RTL and testbench
==================================

MSYNC_SEQUENCER -- requirements
Module: msync_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the delay, length and gap counters.
REQ-002 SHALL have parameter REP_W, default 16, width of the repeat count and run counter.
REQ-003 SHALL have clock clk; reset reset, synchronous, active-high.
REQ-004 SHALL have ports: clk  input  1  clock; reset  input  1  sync active-high reset.
REQ-005 SHALL have ports: arm  input  1  pulse, starts a sequence from IDLE; abort  input  1  pulse, terminates any sequence.
REQ-006 SHALL have port: trig  input  1  external trigger, level-sampled each cycle.
REQ-007 SHALL have ports: cfg_delay  input  CNT_W  trigger-to-start cycles; cfg_length  input  CNT_W  acquisition cycles; cfg_gap  input  CNT_W  post-run holdoff cycles; cfg_repeat  input  REP_W  run count, 0 = continuous.
REQ-008 SHALL have ports: start_daq  output  1  one-cycle pulse; stop_daq  output  1  one-cycle pulse (both drive the DAQ-enable machine).
REQ-009 SHALL have ports: busy  output  1  state != IDLE; done  output  1  one-cycle pulse at sequence end; run_count  output  REP_W  completed runs; state  output  3  current state code.

Function
REQ-010 SHALL implement states IDLE=0, ARMED=1, DELAY=2, ACQ=3, GAP=4; all outputs registered.
REQ-011 SHALL, on arm in IDLE, latch all cfg_* inputs, clear run_count, and enter ARMED the next cycle; cfg_* changes afterwards SHALL have no effect until the next arm.
REQ-012 SHALL ignore arm outside IDLE, and ignore trig outside ARMED.
REQ-013 SHALL, on trig sampled high in ARMED at cycle N, assert start_daq at cycle N+1+delay and be in ACQ at that cycle; delay=0 gives DELAY skipped, start at N+1.
REQ-014 SHALL assert stop_daq exactly L cycles after start_daq, where L = cfg_length, with length 0 treated as 1; start_daq and stop_daq SHALL never be high in the same cycle.
REQ-015 SHALL increment run_count in the cycle stop_daq is asserted, saturating at all-ones.
REQ-016 SHALL, after stop_daq, when repeat!=0 and run_count reaches repeat: pulse done with stop_daq and enter IDLE; otherwise enter GAP for gap cycles (0 = skip), then ARMED.
REQ-017 SHALL NOT latch a trig high during GAP; a trigger first counts in ARMED.
REQ-018 SHALL, on abort in ACQ, pulse stop_daq next cycle; abort in any other non-IDLE state SHALL NOT pulse stop_daq; in all cases it SHALL go to IDLE next cycle and pulse done.
REQ-019 SHALL give abort priority over arm, trig and counter expiry in the same cycle, and SHALL ignore abort in IDLE.
REQ-020 SHALL hold the invariant: start_daq and stop_daq pulses strictly alternate, starting with start_daq.

Reset
REQ-021 SHALL, on reset, force state IDLE, start_daq=0, stop_daq=0, done=0, busy=0, run_count=0 and counters=0 in the following cycle.
REQ-022 SHALL NOT emit stop_daq on reset mid-ACQ; the DAQ-enable machine shares the reset.

Structure
REQ-023 SHALL place state encodings and default CNT_W/REP_W in shared package msync_pkg.
REQ-024 SHALL use one sub-module msync_down_cnt: a loadable CNT_W down-counter with load, enable and a zero flag, reused for the delay, length and gap phases.

Verification
REQ-025 SHALL verify: delay=3, length=5, repeat=1, trig at cycle 10 -> start_daq at 14, stop_daq at 19, done at 19, busy low at 20.
REQ-026 SHALL verify: repeat=3, gap=2, trig held high -> three start/stop pairs, run_count 1,2,3, with a single done after the third stop.
REQ-027 SHALL verify: abort two cycles into ACQ -> stop_daq next cycle, IDLE, done pulse; a second arm then works normally.
REQ-028 SHALL verify: delay=0, length=0 -> start at N+1, stop at N+2.
REQ-029 SHALL verify: reset mid-DELAY and mid-ACQ -> all outputs 0 next cycle, no stop_daq; trig/arm pulses while busy -> ignored.
REQ-030 SHALL verify: repeat=0 -> continuous runs until abort; run_count saturates when preloaded near max via small REP_W=2.

Source files
------------

// File: rtl/msync_pkg.sv
// msync_pkg: definitions shared by the measurement-sync sequencer.
//   MSYNC_CNT_W   default width of the delay/length/gap counters
//   MSYNC_REP_W   default width of the repeat count and run counter
//   msync_state_e sequencer state codes, also driven out on the state port
package msync_pkg;

  localparam int MSYNC_CNT_W = 32;
  localparam int MSYNC_REP_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_ACQ   = 3'd3,
    ST_GAP   = 3'd4
  } msync_state_e;

endpackage

// File: rtl/msync_down_cnt.sv
// msync_down_cnt: loadable down-counter that stops at zero.
//   clk, reset   clock and synchronous active-high reset (count -> 0)
//   load_i       load load_val_i this cycle (wins over en_i)
//   en_i         decrement by one while the count is non-zero
//   load_val_i   value to load
//   zero_o       count is zero
module msync_down_cnt
  import msync_pkg::*;
#(
  parameter int CNT_W = MSYNC_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/msync_sequencer.sv
// msync_sequencer: trigger-driven acquisition sequencer.
// After arm the block waits for trig, waits cfg_delay cycles, pulses start_daq,
// waits the acquisition length, pulses stop_daq, then either finishes (repeat
// count reached) or holds off cfg_gap cycles and re-arms. abort ends any
// sequence, closing an open acquisition with a stop_daq pulse.
//   clk, reset          clock, synchronous active-high reset
//   arm                 start a sequence (IDLE only); latches all cfg_* inputs
//   abort               terminate the current sequence (ignored in IDLE)
//   trig                trigger, sampled each cycle while ARMED
//   cfg_delay           trigger-to-start cycles
//   cfg_length          acquisition cycles (0 behaves as 1)
//   cfg_gap             holdoff cycles between runs
//   cfg_repeat          runs per sequence, 0 = run until abort
//   start_daq, stop_daq one-cycle DAQ enable/disable pulses
//   busy                not IDLE
//   done                one-cycle pulse at the end of a sequence
//   run_count           completed runs, saturating
//   state               current state code
module msync_sequencer
  import msync_pkg::*;
#(
  parameter int CNT_W = MSYNC_CNT_W,
  parameter int REP_W = MSYNC_REP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_length,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [REP_W-1:0] cfg_repeat,
  output logic             start_daq,
  output logic             stop_daq,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] run_count,
  output logic [2:0]       state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

  msync_state_e     state_q, state_d;
  logic             start_q, start_d;
  logic             stop_q, stop_d;
  logic             done_q, done_d;
  logic             busy_q;
  logic [REP_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] length_q, length_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [REP_W-1:0] repeat_q, repeat_d;

  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  logic [CNT_W-1:0] len_m1;
  logic [REP_W-1:0] run_inc;

  // The counter is loaded with (phase length - 1) on entry, so a phase of n
  // cycles ends on the cycle the counter reads zero.
  assign len_m1  = (length_q == '0) ? '0 : (length_q - CNT_ONE);
  assign run_inc = (run_q == {REP_W{1'b1}}) ? run_q : (run_q + REP_ONE);

  msync_down_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    stop_d   = 1'b0;
    done_d   = 1'b0;
    run_d    = run_q;
    delay_d  = delay_q;
    length_d = length_q;
    gap_d    = gap_q;
    repeat_d = repeat_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          delay_d  = cfg_delay;
          length_d = cfg_length;
          gap_d    = cfg_gap;
          repeat_d = cfg_repeat;
          run_d    = '0;
          state_d  = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (abort) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (trig) begin
          cnt_load = 1'b1;
          if (delay_q == '0) begin
            start_d = 1'b1;
            cnt_val = len_m1;
            state_d = ST_ACQ;
          end else begin
            cnt_val = delay_q - CNT_ONE;
            state_d = ST_DELAY;
          end
        end
      end

      ST_DELAY: begin
        if (abort) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          start_d  = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = len_m1;
          state_d  = ST_ACQ;
        end else begin
          cnt_en = 1'b1;
        end
      end

      // ACQ also covers the cycle in which stop_daq is high; the run's exit
      // is decided there, using done_q as the "last run" flag.
      ST_ACQ: begin
        if (abort) begin
          if (!stop_q) begin
            stop_d = 1'b1;
            run_d  = run_inc;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (stop_q) begin
          if (done_q) begin
            state_d = ST_IDLE;
          end else if (gap_q == '0) begin
            state_d = ST_ARMED;
          end else begin
            cnt_load = 1'b1;
            cnt_val  = gap_q - CNT_ONE;
            state_d  = ST_GAP;
          end
        end else if (cnt_zero) begin
          stop_d = 1'b1;
          run_d  = run_inc;
          done_d = (repeat_q != '0) && (run_inc == repeat_q);
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_GAP: begin
        if (abort) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_ARMED;
        end else begin
          cnt_en = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      run_q    <= '0;
      delay_q  <= '0;
      length_q <= '0;
      gap_q    <= '0;
      repeat_q <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      done_q   <= done_d;
      busy_q   <= (state_d != ST_IDLE);
      run_q    <= run_d;
      delay_q  <= delay_d;
      length_q <= length_d;
      gap_q    <= gap_d;
      repeat_q <= repeat_d;
    end
  end

  assign start_daq = start_q;
  assign stop_daq  = stop_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign run_count = run_q;
  assign state     = state_q;

endmodule

// File: tb/tb_msync_sequencer.sv
module tb_msync_sequencer;

  logic        clk = 1'b0;
  logic        reset, arm, abort, trig;
  logic [31:0] cfg_delay, cfg_length, cfg_gap;
  logic [15:0] cfg_repeat;

  logic        start0, stop0, busy0, done0;
  logic [15:0] run0;
  logic [2:0]  state0;
  logic        start1, stop1, busy1, done1;
  logic [1:0]  run1;
  logic [2:0]  state1;

  always #5 clk = ~clk;

  msync_sequencer dut0 (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trig(trig),
    .cfg_delay(cfg_delay), .cfg_length(cfg_length), .cfg_gap(cfg_gap),
    .cfg_repeat(cfg_repeat),
    .start_daq(start0), .stop_daq(stop0), .busy(busy0), .done(done0),
    .run_count(run0), .state(state0)
  );

  msync_sequencer #(.CNT_W(32), .REP_W(2)) dut1 (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trig(trig),
    .cfg_delay(cfg_delay), .cfg_length(cfg_length), .cfg_gap(cfg_gap),
    .cfg_repeat(cfg_repeat[1:0]),
    .start_daq(start1), .stop_daq(stop1), .busy(busy1), .done(done1),
    .run_count(run1), .state(state1)
  );

  // observed output bundles: {start, stop, done, busy, state, run_count}
  logic [22:0] obs [2];
  assign obs[0] = {start0, stop0, done0, busy0, state0, run0};
  assign obs[1] = {start1, stop1, done1, busy1, state1, 14'd0, run1};

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Reference model: a sequence is described by absolute cycle numbers --
  // when triggers start to count, when the DAQ starts and when it stops.
  int m_idle [2];
  int m_in_run [2];
  int m_final [2];
  int m_armed_from [2];
  int m_start [2];
  int m_stop [2];
  int m_runs [2];
  int m_d [2], m_l [2], m_g [2], m_rep [2];

  logic        e_start [2], e_stop [2], e_done [2], e_busy [2];
  logic [2:0]  e_state [2];
  logic [15:0] e_runs [2];
  logic [22:0] e_vec [2];

  // Inputs present during cycle c; expectations are for cycle c+1.
  task automatic model_update(input int c);
    for (int k = 0; k < 2; k++) begin
      int mx;
      mx = (k == 0) ? 65535 : 3;
      e_start[k] = 1'b0;
      e_stop[k]  = 1'b0;
      e_done[k]  = 1'b0;
      if (reset) begin
        m_idle[k] = 1; m_in_run[k] = 0; m_runs[k] = 0; m_final[k] = 0;
      end else if (m_idle[k] != 0) begin
        if (arm) begin
          m_d[k]   = int'(cfg_delay);
          m_l[k]   = (cfg_length == 0) ? 1 : int'(cfg_length);
          m_g[k]   = int'(cfg_gap);
          m_rep[k] = (k == 0) ? int'(cfg_repeat) : int'(cfg_repeat % 16'd4);
          m_runs[k] = 0; m_final[k] = 0; m_idle[k] = 0; m_in_run[k] = 0;
          m_armed_from[k] = c + 1;
        end
      end else if (abort) begin
        if (m_in_run[k] != 0 && c >= m_start[k] && c < m_stop[k]) begin
          e_stop[k] = 1'b1;
          m_runs[k] = (m_runs[k] == mx) ? mx : m_runs[k] + 1;
        end
        e_done[k] = 1'b1; m_idle[k] = 1; m_in_run[k] = 0;
      end else if (m_in_run[k] == 0) begin
        if (trig && c >= m_armed_from[k]) begin
          m_in_run[k] = 1; m_final[k] = 0;
          m_start[k] = c + 1 + m_d[k];
          m_stop[k]  = m_start[k] + m_l[k];
        end
      end else begin
        if (c + 1 == m_stop[k]) begin
          e_stop[k] = 1'b1;
          m_runs[k] = (m_runs[k] == mx) ? mx : m_runs[k] + 1;
          m_final[k] = (m_rep[k] != 0 && m_runs[k] == m_rep[k]) ? 1 : 0;
          e_done[k] = (m_final[k] != 0);
        end
        if (c == m_stop[k]) begin
          m_in_run[k] = 0;
          if (m_final[k] != 0) m_idle[k] = 1;
          else m_armed_from[k] = c + 1 + m_g[k];
        end
      end
      e_start[k] = !reset && (m_in_run[k] != 0) && (c + 1 == m_start[k]);
      e_busy[k]  = (m_idle[k] == 0);
      if (m_idle[k] != 0)        e_state[k] = 3'd0;
      else if (m_in_run[k] != 0) e_state[k] = (c + 1 < m_start[k]) ? 3'd2 : 3'd3;
      else                       e_state[k] = (c + 1 < m_armed_from[k]) ? 3'd4 : 3'd1;
      e_runs[k] = 16'(m_runs[k]);
      e_vec[k]  = {e_start[k], e_stop[k], e_done[k], e_busy[k], e_state[k], e_runs[k]};
    end
  endtask

  task automatic step();
    model_update(cyc);
    @(posedge clk);
    #1;
    cyc++;
    if (start0 || stop0 || done0)
      $display("cyc %0d dut0 start=%0b stop=%0b done=%0b run_count=%0d state=%0d",
               cyc, start0, stop0, done0, run0, state0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step(); step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 23'd0) $display("FAIL reset_zero dut%0d got %h want 0", k, obs[k]);
      else passes++;
      checks++;
      if (obs[k] !== e_vec[k]) $display("FAIL reset_model dut%0d got %h want %h", k, obs[k], e_vec[k]);
      else passes++;
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_run();
    int t0;
    int t_start = -1, t_stop = -1, t_done = -1, t_idle = -1;
    cfg_delay = 3; cfg_length = 5; cfg_gap = 0; cfg_repeat = 1;
    arm = 1'b1; step(); arm = 1'b0;
    cfg_delay = 9; cfg_length = 1; cfg_gap = 7; cfg_repeat = 0;
    step(); step();
    trig = 1'b1; t0 = cyc; step(); trig = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== e_vec[k])
          $display("FAIL single_run dut%0d cyc %0d got %h want %h", k, cyc, obs[k], e_vec[k]);
        else passes++;
      end
      if (start0 && t_start < 0) t_start = cyc;
      if (stop0 && t_stop < 0)   t_stop = cyc;
      if (done0 && t_done < 0)   t_done = cyc;
      if (!busy0 && t_idle < 0)  t_idle = cyc;
    end
    checks++;
    if (t_start !== t0 + 4) $display("FAIL single_start_cyc got %0d want %0d", t_start, t0 + 4);
    else passes++;
    checks++;
    if (t_stop !== t0 + 9) $display("FAIL single_stop_cyc got %0d want %0d", t_stop, t0 + 9);
    else passes++;
    checks++;
    if (t_done !== t0 + 9) $display("FAIL single_done_cyc got %0d want %0d", t_done, t0 + 9);
    else passes++;
    checks++;
    if (t_idle !== t0 + 10) $display("FAIL single_idle_cyc got %0d want %0d", t_idle, t0 + 10);
    else passes++;
  endtask

  task automatic test_repeat();
    int starts = 0, stops = 0, dones = 0, done_cyc = -1, third_stop = -2;
    logic [15:0] rc [3];
    cfg_delay = 1; cfg_length = 2; cfg_gap = 2; cfg_repeat = 3;
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== e_vec[k])
          $display("FAIL repeat dut%0d cyc %0d got %h want %h", k, cyc, obs[k], e_vec[k]);
        else passes++;
      end
      if (start0) starts++;
      if (stop0) begin
        if (stops < 3) rc[stops] = run0;
        stops++;
        if (stops == 3) third_stop = cyc;
      end
      if (done0) begin dones++; done_cyc = cyc; end
    end
    trig = 1'b0;
    checks++;
    if (starts != 3 || stops != 3) $display("FAIL repeat_pairs got %0d/%0d want 3/3", starts, stops);
    else passes++;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (rc[j] !== 16'(j + 1)) $display("FAIL repeat_run_count%0d got %0d want %0d", j, rc[j], j + 1);
      else passes++;
    end
    checks++;
    if (dones != 1 || done_cyc != third_stop)
      $display("FAIL repeat_done got %0d at %0d want 1 at %0d", dones, done_cyc, third_stop);
    else passes++;
  endtask

  task automatic test_abort_acq();
    int starts = 0, stops = 0;
    cfg_delay = 0; cfg_length = 10; cfg_gap = 0; cfg_repeat = 1;
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; step(); trig = 1'b0;
    checks++;
    if (start0 !== 1'b1) $display("FAIL abort_first_start got %b want 1", start0);
    else passes++;
    step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if ({stop0, done0, busy0, state0} !== 6'b110_000)
      $display("FAIL abort_result got stop=%b done=%b busy=%b state=%0d want 1 1 0 0",
               stop0, done0, busy0, state0);
    else passes++;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== e_vec[k]) $display("FAIL abort_model dut%0d got %h want %h", k, obs[k], e_vec[k]);
      else passes++;
    end
    cfg_delay = 1; cfg_length = 3;
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; step(); trig = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== e_vec[k])
          $display("FAIL rearm dut%0d cyc %0d got %h want %h", k, cyc, obs[k], e_vec[k]);
        else passes++;
      end
      if (start0) starts++;
      if (stop0) stops++;
    end
    checks++;
    if (starts != 1 || stops != 1 || state0 !== 3'd0)
      $display("FAIL rearm_run got %0d/%0d state %0d want 1/1 state 0", starts, stops, state0);
    else passes++;
  endtask

  task automatic test_zero_delay_length();
    int t0, t_start = -1, t_stop = -1;
    cfg_delay = 0; cfg_length = 0; cfg_gap = 0; cfg_repeat = 1;
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; t0 = cyc; step(); trig = 1'b0;
    if (start0) t_start = cyc;
    for (int i = 0; i < 4; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== e_vec[k])
          $display("FAIL zero_cfg dut%0d cyc %0d got %h want %h", k, cyc, obs[k], e_vec[k]);
        else passes++;
      end
      if (stop0 && t_stop < 0) t_stop = cyc;
    end
    checks++;
    if (t_start != t0 + 1 || t_stop != t0 + 2)
      $display("FAIL zero_cfg_timing got start %0d stop %0d want %0d %0d", t_start, t_stop, t0 + 1, t0 + 2);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int stops, starts;
    for (int phase = 0; phase < 2; phase++) begin
      cfg_delay = (phase == 0) ? 6 : 0; cfg_length = 8; cfg_gap = 0; cfg_repeat = 1;
      arm = 1'b1; step(); arm = 1'b0;
      trig = 1'b1; step(); trig = 1'b0;
      step(); step();
      reset = 1'b1; step(); reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== 23'd0) $display("FAIL reset_mid%0d dut%0d got %h want 0", phase, k, obs[k]);
        else passes++;
      end
      stops = 0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (stop0 || stop1) stops++;
      end
      checks++;
      if (stops != 0) $display("FAIL reset_mid%0d_nostop got %0d stops want 0", phase, stops);
      else passes++;
    end
    // arm and trig toggling while busy must not disturb the run
    cfg_delay = 2; cfg_length = 6; cfg_repeat = 1;
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; step(); trig = 1'b0;
    starts = 0; stops = 0;
    for (int i = 0; i < 20; i++) begin
      arm  = (i < 8) && (i % 2 == 0);
      trig = (i < 8) && (i % 2 == 1);
      cfg_delay = 0; cfg_length = 1;
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== e_vec[k])
          $display("FAIL busy_ignore dut%0d cyc %0d got %h want %h", k, cyc, obs[k], e_vec[k]);
        else passes++;
      end
      if (start0) starts++;
      if (stop0) stops++;
    end
    arm = 1'b0; trig = 1'b0;
    checks++;
    if (starts != 1 || stops != 1) $display("FAIL busy_ignore_pairs got %0d/%0d want 1/1", starts, stops);
    else passes++;
  endtask

  task automatic test_continuous();
    cfg_delay = 0; cfg_length = 1; cfg_gap = 0; cfg_repeat = 0;
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== e_vec[k])
          $display("FAIL continuous dut%0d cyc %0d got %h want %h", k, cyc, obs[k], e_vec[k]);
        else passes++;
      end
    end
    trig = 1'b0;
    checks++;
    if (run1 !== 2'd3 || busy1 !== 1'b1) $display("FAIL continuous_sat got run=%0d busy=%b want 3 1", run1, busy1);
    else passes++;
    checks++;
    if (!(run0 > 16'd3)) $display("FAIL continuous_wide got run=%0d want >3", run0);
    else passes++;
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if ({done0, busy0, done1, busy1} !== 4'b1010)
      $display("FAIL continuous_abort got %b want 1010", {done0, busy0, done1, busy1});
    else passes++;
  endtask

  task automatic test_random();
    logic last_start = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      arm        = ($urandom_range(0, 7) == 0);
      abort      = ($urandom_range(0, 59) == 0);
      trig       = ($urandom_range(0, 1) == 1);
      cfg_delay  = $urandom_range(0, 4);
      cfg_length = $urandom_range(0, 5);
      cfg_gap    = $urandom_range(0, 3);
      cfg_repeat = 16'($urandom_range(0, 4));
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== e_vec[k])
          $display("FAIL random dut%0d cyc %0d got %h want %h", k, cyc, obs[k], e_vec[k]);
        else passes++;
      end
      if (start0 || stop0) begin
        checks++;
        if ((start0 && stop0) || (start0 && last_start) || (stop0 && !last_start))
          $display("FAIL alternation cyc %0d got start=%b stop=%b prev_start=%b", cyc, start0, stop0, last_start);
        else passes++;
        last_start = start0;
      end
      if (reset) last_start = 1'b0;
    end
    reset = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0;
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0;
    cfg_delay = 0; cfg_length = 0; cfg_gap = 0; cfg_repeat = 0;
    test_reset();
    test_single_run();
    test_repeat();
    test_abort_acq();
    test_zero_delay_length();
    test_reset_mid();
    test_continuous();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
